// File: rtl/regfile_writer_pkg.sv
// Shared types and helpers for the rotating register-file write allocator.
// The typedefs describe the default configuration; modules re-derive widths when LOG2REGS is overridden.
package regfile_writer_pkg;

  localparam int LOG2REGS_DEF = 1;

  typedef logic [LOG2REGS_DEF-1:0] ptr_t;
  typedef logic [LOG2REGS_DEF:0]   count_t;

  function automatic int depth_of(input int log2regs);
    return 1 << log2regs;
  endfunction

endpackage

// File: rtl/regfile_rotating_writer_ptr.sv
// rf_wrap_ptr: modulo-DEPTH pointer with increment enable, used for both head and tail.
module rf_wrap_ptr
  import regfile_writer_pkg::*;
#(
  parameter int LOG2REGS = $bits(ptr_t)
) (
  input  logic                CGRA_Clock,
  input  logic                CGRA_Reset,
  input  logic                inc,
  output logic [LOG2REGS-1:0] ptr
);

  localparam logic [LOG2REGS-1:0] LAST = LOG2REGS'(depth_of(LOG2REGS) - 1);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CGRA_Clock or posedge CGRA_Reset) begin
    if (CGRA_Reset)
      ptr <= '0;
    else if (inc)
      ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
  end

endmodule

// File: rtl/regfile_rotating_writer.sv
// Write-side allocator for the 1W/2R register file with rotating head/tail pointers.
// Optional build macro REGFILE_WRITER_ERR_EN enables the sticky underflow_err register.
module regfile_rotating_writer
  import regfile_writer_pkg::*;
#(
  parameter int LOG2REGS = $bits(ptr_t),
  parameter int SIZE     = 32
) (
  input  logic                CGRA_Clock,
  input  logic                CGRA_Reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [SIZE-1:0]     in_data,
  input  logic                release_strobe,
  output logic                WE0,
  output logic [LOG2REGS-1:0] address_in0,
  output logic [SIZE-1:0]     data_out,
  output logic [LOG2REGS-1:0] head_addr,
  output logic [LOG2REGS:0]   count,
  output logic                full,
  output logic                empty,
  output logic                underflow_err
);

  localparam int DEPTH = depth_of(LOG2REGS);

  logic [LOG2REGS-1:0] tail;
  logic [LOG2REGS+1:0] occupancy;
  logic                accept;
  logic                rel_eff;

  // An issued-but-not-landed write already owns its register, so it counts toward full.
  assign occupancy = {1'b0, count} + {{(LOG2REGS+1){1'b0}}, WE0};
  assign full      = (occupancy == (LOG2REGS+2)'(DEPTH));
  assign empty     = (count == '0);
  assign in_ready  = !full;
  assign accept    = in_valid && in_ready;
  assign rel_eff   = release_strobe && !empty;

  rf_wrap_ptr #(.LOG2REGS(LOG2REGS)) u_tail (
    .CGRA_Clock (CGRA_Clock),
    .CGRA_Reset (CGRA_Reset),
    .inc        (accept),
    .ptr        (tail)
  );

  rf_wrap_ptr #(.LOG2REGS(LOG2REGS)) u_head (
    .CGRA_Clock (CGRA_Clock),
    .CGRA_Reset (CGRA_Reset),
    .inc        (rel_eff),
    .ptr        (head_addr)
  );

  always_ff @(posedge CGRA_Clock or posedge CGRA_Reset) begin
    if (CGRA_Reset) begin
      WE0         <= 1'b0;
      address_in0 <= '0;
      data_out    <= '0;
    end else begin
      WE0 <= accept;
      if (accept) begin
        address_in0 <= tail;
        data_out    <= in_data;
      end
    end
  end

  // A landing write and an effective release on the same edge cancel out.
  always_ff @(posedge CGRA_Clock or posedge CGRA_Reset) begin
    if (CGRA_Reset)
      count <= '0;
    else if (WE0 && !rel_eff)
      count <= count + 1'b1;
    else if (!WE0 && rel_eff)
      count <= count - 1'b1;
  end

`ifdef REGFILE_WRITER_ERR_EN
  always_ff @(posedge CGRA_Clock or posedge CGRA_Reset) begin
    if (CGRA_Reset)
      underflow_err <= 1'b0;
    else if (release_strobe && empty)
      underflow_err <= 1'b1;
  end
`else
  assign underflow_err = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_rotating_writer.sv
// Scoreboard bench for regfile_rotating_writer: directed vectors, writes checked by a negedge monitor.
module tb_regfile_rotating_writer;

  localparam int LOG2REGS = 2;
  localparam int SIZE     = 32;
`ifdef REGFILE_WRITER_ERR_EN
  localparam logic UF_EXP = 1'b1;
`else
  localparam logic UF_EXP = 1'b0;
`endif

  logic                CGRA_Clock = 1'b0;
  logic                CGRA_Reset;
  logic                in_valid;
  logic                in_ready;
  logic [SIZE-1:0]     in_data;
  logic                release_strobe;
  logic                WE0;
  logic [LOG2REGS-1:0] address_in0;
  logic [SIZE-1:0]     data_out;
  logic [LOG2REGS-1:0] head_addr;
  logic [LOG2REGS:0]   count;
  logic                full;
  logic                empty;
  logic                underflow_err;

  typedef struct packed {
    logic [LOG2REGS-1:0] addr;
    logic [SIZE-1:0]     data;
  } wr_t;

  wr_t sb[$];
  int  checks   = 0;
  int  failures = 0;

  always #5 CGRA_Clock = ~CGRA_Clock;

  regfile_rotating_writer #(.LOG2REGS(LOG2REGS), .SIZE(SIZE)) dut (
    .CGRA_Clock     (CGRA_Clock),
    .CGRA_Reset     (CGRA_Reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .release_strobe (release_strobe),
    .WE0            (WE0),
    .address_in0    (address_in0),
    .data_out       (data_out),
    .head_addr      (head_addr),
    .count          (count),
    .full           (full),
    .empty          (empty),
    .underflow_err  (underflow_err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic state(input string tag, input int cnt, input int hd, input logic fl);
    check({tag, ".count"}, 64'(count), 64'(cnt));
    check({tag, ".head"}, 64'(head_addr), 64'(hd));
    check({tag, ".full"}, 64'(full), 64'(fl));
    check({tag, ".empty"}, 64'(empty), 64'(cnt == 0));
    check({tag, ".in_ready"}, 64'(in_ready), 64'(!fl));
  endtask

  task automatic push(input int addr, input logic [SIZE-1:0] data);
    wr_t w;
    w.addr = LOG2REGS'(addr);
    w.data = data;
    sb.push_back(w);
    in_data = data;
  endtask

  task automatic tick();
    @(posedge CGRA_Clock);
    #1;
  endtask

  // Every registered write presented to the register file must match the oldest expectation.
  always @(negedge CGRA_Clock) begin
    if (!CGRA_Reset && WE0 === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_write", 64'(WE0), 64'd0);
      end else begin
        wr_t w;
        w = sb.pop_front();
        check("wr_addr", 64'(address_in0), 64'(w.addr));
        check("wr_data", 64'(data_out), 64'(w.data));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    in_valid       = 1'b0;
    in_data        = '0;
    release_strobe = 1'b0;
    CGRA_Reset     = 1'b1;
    repeat (2) tick();
    check("rst.WE0", 64'(WE0), 64'd0);
    check("rst.addr", 64'(address_in0), 64'd0);
    check("rst.data", 64'(data_out), 64'd0);
    check("rst.uflow", 64'(underflow_err), 64'd0);
    state("rst", 0, 0, 1'b0);
    CGRA_Reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      tick();
      state("idle", 0, 0, 1'b0);
    end

    // Three back-to-back accepts to addresses 0..2
    in_valid = 1'b1;
    push(0, 32'hA0); tick(); state("acc0", 0, 0, 1'b0);
    push(1, 32'hA1); tick(); state("acc1", 1, 0, 1'b0);
    push(2, 32'hA2); tick(); state("acc2", 2, 0, 1'b0);
    in_valid = 1'b0;
    tick(); state("cnt3", 3, 0, 1'b0);
    check("cnt3.WE0", 64'(WE0), 64'd0);

    // Fourth accept fills; valid stays high but no fifth write may issue
    in_valid = 1'b1;
    push(3, 32'hB3); tick(); state("acc3", 3, 0, 1'b1);
    in_data = 32'hB4;
    tick(); state("full4", 4, 0, 1'b1);
    check("full4.WE0", 64'(WE0), 64'd0);
    tick(); state("full4b", 4, 0, 1'b1);

    // Release while full, then the pending valid is accepted at wrapped address 0
    release_strobe = 1'b1;
    in_data = 32'hC0;
    tick(); state("rel_full", 3, 1, 1'b0);
    release_strobe = 1'b0;
    push(0, 32'hC0); tick(); state("acc_wrap", 3, 1, 1'b1);
    in_valid = 1'b0;
    tick(); state("refull", 4, 1, 1'b1);

    // Drain to 2, then make a landing write coincide with a release
    release_strobe = 1'b1;
    tick(); state("drain3", 3, 2, 1'b0);
    tick(); state("drain2", 2, 3, 1'b0);
    release_strobe = 1'b0;
    in_valid = 1'b1;
    push(1, 32'hD1); tick(); state("acc_d1", 2, 3, 1'b0);
    in_valid = 1'b0;
    release_strobe = 1'b1;
    tick(); state("land_rel", 2, 0, 1'b0);
    release_strobe = 1'b0;
    in_valid = 1'b1;
    push(2, 32'hD2); tick(); state("acc_d2", 2, 0, 1'b0);
    in_valid = 1'b0;
    tick(); state("cnt3b", 3, 0, 1'b0);

    // Drain to empty, then release with nothing live
    check("pre_uflow", 64'(underflow_err), 64'd0);
    release_strobe = 1'b1;
    tick(); state("dr2", 2, 1, 1'b0);
    tick(); state("dr1", 1, 2, 1'b0);
    tick(); state("dr0", 0, 3, 1'b0);
    tick(); state("uflow", 0, 3, 1'b0);
    check("uflow.err", 64'(underflow_err), 64'(UF_EXP));
    release_strobe = 1'b0;
    repeat (3) tick();
    check("uflow.sticky", 64'(underflow_err), 64'(UF_EXP));
    state("uflow_idle", 0, 3, 1'b0);

    // Asynchronous reset clears sticky error and pointers
    CGRA_Reset = 1'b1;
    #1;
    check("rst2.uflow", 64'(underflow_err), 64'd0);
    state("rst2", 0, 0, 1'b0);
    check("sb_drained", 64'(sb.size()), 64'd0);
    CGRA_Reset = 1'b0;
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
